// File: rtl/cnn_layer_accel_quad_job_seq.sv
// Job sequencer for one cnn_layer_accel quad: descriptor intake, quad handshake, fetch forwarding, watchdog.
// Latency: descriptor accepted at cycle N -> job_start high at N+1; every output is registered.
// Backpressure: job_desc_ready is high only in IDLE; the quad and fetch engine hold levels until answered.
module cnn_layer_accel_quad_job_seq #(
  parameter int          C_CNT_WIDTH      = 16,
  parameter int unsigned C_TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   job_desc_valid,
  output logic                   job_desc_ready,
  input  logic [127:0]           job_desc_data,
  output logic                   job_start,
  input  logic                   job_accept,
  output logic [127:0]           job_parameters,
  input  logic                   job_fetch_request,
  output logic                   job_fetch_ack,
  output logic                   job_fetch_complete,
  input  logic                   job_complete,
  output logic                   job_complete_ack,
  output logic                   fetch_req,
  input  logic                   fetch_done,
  input  logic                   clear_err,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [C_CNT_WIDTH-1:0] jobs_done_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_FETCH = 3'd3,
    S_CMPL  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [127:0]           params_q, params_d;
  logic                   start_q, start_d;
  logic                   fack_q, fack_d;
  logic                   fcmpl_q, fcmpl_d;
  logic                   cack_q, cack_d;
  logic                   freq_q, freq_d;
  logic                   rdy_q, rdy_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]            wd_q, wd_d;
  logic                   active;

  // Next-state and registered-output computation; watchdog overrides the handshake when it fires.
  always_comb begin
    state_d  = state_q;
    params_d = params_q;
    start_d  = start_q;
    fack_d   = 1'b0;
    fcmpl_d  = 1'b0;
    cack_d   = cack_q;
    freq_d   = freq_q;
    rdy_d    = rdy_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    wd_d     = 32'd0;
    active   = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (job_desc_valid) begin
          params_d = job_desc_data;
          start_d  = 1'b1;
          rdy_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        active = 1'b1;
        if (job_accept) begin
          start_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        active = 1'b1;
        // Completion wins over a simultaneous fetch request.
        if (job_complete) begin
          cack_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_CMPL;
        end else if (job_fetch_request) begin
          fack_d  = 1'b1;
          freq_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        active = 1'b1;
        if (fetch_done) begin
          freq_d  = 1'b0;
          fcmpl_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_CMPL: begin
        active = 1'b1;
        if (!job_complete) begin
          cack_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (clear_err) begin
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
    endcase

    // Watchdog counts dwell time in the current state; any transition restarts it.
    if (active && (state_d == state_q)) begin
      if ((C_TIMEOUT_CYCLES != 0) && (wd_q == (C_TIMEOUT_CYCLES - 32'd1))) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        start_d = 1'b0;
        fack_d  = 1'b0;
        fcmpl_d = 1'b0;
        cack_d  = 1'b0;
        freq_d  = 1'b0;
        rdy_d   = 1'b0;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      params_q <= '0;
      start_q  <= 1'b0;
      fack_q   <= 1'b0;
      fcmpl_q  <= 1'b0;
      cack_q   <= 1'b0;
      freq_q   <= 1'b0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      wd_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      params_q <= params_d;
      start_q  <= start_d;
      fack_q   <= fack_d;
      fcmpl_q  <= fcmpl_d;
      cack_q   <= cack_d;
      freq_q   <= freq_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
    end
  end

  assign job_desc_ready     = rdy_q;
  assign job_start          = start_q;
  assign job_parameters     = params_q;
  assign job_fetch_ack      = fack_q;
  assign job_fetch_complete = fcmpl_q;
  assign job_complete_ack   = cack_q;
  assign fetch_req          = freq_q;
  assign busy               = busy_q;
  assign timeout_err        = err_q;
  assign jobs_done_count    = cnt_q;

endmodule

// File: tb/tb_cnn_layer_accel_quad_job_seq.sv
// Directed bench: instance A uses default parameters, instance B a 2-bit counter and 16-cycle watchdog.
// Both instances share stimulus; each has its own reset so only the one under test is live.
module tb_cnn_layer_accel_quad_job_seq;

  logic         clk = 1'b0;
  logic         rst_a, rst_b;
  logic         desc_vld, accept, freq, jcmpl, fdone, clr;
  logic [127:0] desc_dat;

  logic         a_rdy, a_start, a_fack, a_fcmpl, a_cack, a_freq, a_busy, a_err;
  logic [127:0] a_par;
  logic [15:0]  a_cnt;
  logic         b_rdy, b_start, b_fack, b_fcmpl, b_cack, b_freq, b_busy, b_err;
  logic [127:0] b_par;
  logic [1:0]   b_cnt;

  int total = 0;
  int bad   = 0;
  int n_fack, n_fcmpl, n_freq;
  logic [1:0] exp_cnt;

  always #5 clk = ~clk;

  cnn_layer_accel_quad_job_seq dut_a (
    .clk_if(clk), .rst(rst_a),
    .job_desc_valid(desc_vld), .job_desc_ready(a_rdy), .job_desc_data(desc_dat),
    .job_start(a_start), .job_accept(accept), .job_parameters(a_par),
    .job_fetch_request(freq), .job_fetch_ack(a_fack), .job_fetch_complete(a_fcmpl),
    .job_complete(jcmpl), .job_complete_ack(a_cack),
    .fetch_req(a_freq), .fetch_done(fdone), .clear_err(clr),
    .busy(a_busy), .timeout_err(a_err), .jobs_done_count(a_cnt)
  );

  cnn_layer_accel_quad_job_seq #(.C_CNT_WIDTH(2), .C_TIMEOUT_CYCLES(16)) dut_b (
    .clk_if(clk), .rst(rst_b),
    .job_desc_valid(desc_vld), .job_desc_ready(b_rdy), .job_desc_data(desc_dat),
    .job_start(b_start), .job_accept(accept), .job_parameters(b_par),
    .job_fetch_request(freq), .job_fetch_ack(b_fack), .job_fetch_complete(b_fcmpl),
    .job_complete(jcmpl), .job_complete_ack(b_cack),
    .fetch_req(b_freq), .fetch_done(fdone), .clear_err(clr),
    .busy(b_busy), .timeout_err(b_err), .jobs_done_count(b_cnt)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; tallies instance A pulse/level cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (a_fack)  n_fack++;
    if (a_fcmpl) n_fcmpl++;
    if (a_freq)  n_freq++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    desc_vld = 1'b0; accept = 1'b0; freq = 1'b0; jcmpl = 1'b0; fdone = 1'b0; clr = 1'b0;
    desc_dat = '0;
    n_fack = 0; n_fcmpl = 0; n_freq = 0;

    // Reset values
    #3;
    chk1("rst_rdy", a_rdy, 1'b1);
    chk1("rst_start", a_start, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_err", a_err, 1'b0);
    chkw("rst_par", a_par, 128'h0);
    chkw("rst_cnt", 128'(a_cnt), 128'd0);
    tick();
    rst_a = 1'b0;
    tick();

    // 1: basic job, accept 3 cycles after start, complete 20 cycles into RUN
    desc_vld = 1'b1; desc_dat = {16{8'hA5}};
    tick();
    desc_vld = 1'b0;
    chk1("t1_start", a_start, 1'b1);
    chk1("t1_rdy_low", a_rdy, 1'b0);
    chk1("t1_busy", a_busy, 1'b1);
    chkw("t1_par", a_par, {16{8'hA5}});
    tick(); tick();
    chk1("t1_start_held", a_start, 1'b1);
    accept = 1'b1;
    tick();
    accept = 1'b0;
    chk1("t1_start_drop", a_start, 1'b0);
    repeat (19) tick();
    chk1("t1_no_ack_yet", a_cack, 1'b0);
    jcmpl = 1'b1;
    tick();
    chk1("t1_cack", a_cack, 1'b1);
    chkw("t1_cnt", 128'(a_cnt), 128'd1);
    tick();
    chk1("t1_cack_held", a_cack, 1'b1);
    jcmpl = 1'b0;
    tick();
    chk1("t1_cack_drop", a_cack, 1'b0);
    chk1("t1_busy_low", a_busy, 1'b0);
    chk1("t1_rdy_back", a_rdy, 1'b1);
    chkw("t1_par_stable", a_par, {16{8'hA5}});

    // 2: two fetches, fetch_done at +5 and +9
    desc_vld = 1'b1; desc_dat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    desc_vld = 1'b0; accept = 1'b1;
    tick();
    accept = 1'b0;
    n_fack = 0; n_fcmpl = 0; n_freq = 0;
    freq = 1'b1;
    tick();
    freq = 1'b0;
    chk1("t2_ack1", a_fack, 1'b1);
    chk1("t2_freq1", a_freq, 1'b1);
    tick();
    chk1("t2_ack1_pulse", a_fack, 1'b0);
    repeat (3) tick();
    chk1("t2_freq1_held", a_freq, 1'b1);
    fdone = 1'b1;
    tick();
    fdone = 1'b0;
    chk1("t2_fcmpl1", a_fcmpl, 1'b1);
    chk1("t2_freq1_drop", a_freq, 1'b0);
    freq = 1'b1;
    tick();
    freq = 1'b0;
    chk1("t2_fcmpl1_pulse", a_fcmpl, 1'b0);
    chk1("t2_ack2", a_fack, 1'b1);
    repeat (8) tick();
    fdone = 1'b1;
    tick();
    fdone = 1'b0;
    chk1("t2_fcmpl2", a_fcmpl, 1'b1);
    tick();
    chkw("t2_n_ack", 128'(n_fack), 128'd2);
    chkw("t2_n_fcmpl", 128'(n_fcmpl), 128'd2);
    chkw("t2_n_freq", 128'(n_freq), 128'd14);
    jcmpl = 1'b1;
    tick();
    jcmpl = 1'b0;
    chkw("t2_cnt", 128'(a_cnt), 128'd2);
    tick();
    chk1("t2_idle", a_busy, 1'b0);

    // 3: complete and fetch request together -> completion wins
    desc_vld = 1'b1; desc_dat = 128'h5A;
    tick();
    desc_vld = 1'b0; accept = 1'b1;
    tick();
    accept = 1'b0; jcmpl = 1'b1; freq = 1'b1;
    tick();
    jcmpl = 1'b0; freq = 1'b0;
    chk1("t3_no_fack", a_fack, 1'b0);
    chk1("t3_no_freq", a_freq, 1'b0);
    chk1("t3_cack", a_cack, 1'b1);
    chkw("t3_cnt", 128'(a_cnt), 128'd3);
    tick();
    chk1("t3_idle_rdy", a_rdy, 1'b1);

    // 6: reset in FETCH, then a normal job
    desc_vld = 1'b1; desc_dat = 128'hBEEF;
    tick();
    desc_vld = 1'b0; accept = 1'b1;
    tick();
    accept = 1'b0; freq = 1'b1;
    tick();
    freq = 1'b0;
    chk1("t6_in_fetch", a_freq, 1'b1);
    rst_a = 1'b1;
    #1;
    chk1("t6_freq_rst", a_freq, 1'b0);
    chk1("t6_busy_rst", a_busy, 1'b0);
    chk1("t6_rdy_rst", a_rdy, 1'b1);
    chkw("t6_par_rst", a_par, 128'h0);
    chkw("t6_cnt_rst", 128'(a_cnt), 128'd0);
    tick();
    rst_a = 1'b0;
    desc_vld = 1'b1; desc_dat = 128'hCAFE;
    tick();
    desc_vld = 1'b0; accept = 1'b1;
    tick();
    accept = 1'b0; jcmpl = 1'b1;
    tick();
    jcmpl = 1'b0;
    chkw("t6_cnt_after", 128'(a_cnt), 128'd1);
    tick();
    chk1("t6_done_rdy", a_rdy, 1'b1);
    chkw("t6_par_after", a_par, 128'hCAFE);

    // 4: watchdog in START on instance B (16 cycles)
    rst_a = 1'b1;
    rst_b = 1'b0;
    tick();
    desc_vld = 1'b1; desc_dat = 128'h77;
    tick();
    desc_vld = 1'b0;
    repeat (15) tick();
    chk1("t4_start_15", b_start, 1'b1);
    chk1("t4_err_15", b_err, 1'b0);
    tick();
    chk1("t4_err_16", b_err, 1'b1);
    chk1("t4_start_off", b_start, 1'b0);
    chk1("t4_busy_err", b_busy, 1'b1);
    chk1("t4_rdy_err", b_rdy, 1'b0);
    tick();
    chk1("t4_err_sticky", b_err, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk1("t4_err_clr", b_err, 1'b0);
    chk1("t4_rdy_clr", b_rdy, 1'b1);
    chk1("t4_busy_clr", b_busy, 1'b0);

    // 5: five back-to-back jobs on the 2-bit counter
    exp_cnt = 2'd0;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = exp_cnt + 2'd1;
      chk1("t5_rdy_idle", b_rdy, 1'b1);
      desc_vld = 1'b1; desc_dat = 128'(i);
      tick();
      desc_vld = 1'b0; accept = 1'b1;
      chk1("t5_rdy_start", b_rdy, 1'b0);
      tick();
      accept = 1'b0; jcmpl = 1'b1;
      chk1("t5_rdy_run", b_rdy, 1'b0);
      tick();
      jcmpl = 1'b0;
      chk1("t5_rdy_cmpl", b_rdy, 1'b0);
      chkw("t5_cnt", 128'(b_cnt), 128'(exp_cnt));
      tick();
    end
    chk1("t5_final_rdy", b_rdy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
